// File: rtl/code_fetch_pkg.sv
// Shared types and constants for the bytecode fetch stage.
// Provides the fetch FSM state enum, opcode constants and the PUSHn width decoder.
// Imported by the interface, the accumulator and the fetch top.
package code_fetch_pkg;

  localparam int unsigned DATA_W = 256;  // PUSH immediate word
  localparam int unsigned LEN_W  = 6;    // holds 0..33

  localparam logic [7:0] OP_STOP   = 8'h00;
  localparam logic [7:0] OP_PUSH0  = 8'h5F;
  localparam logic [7:0] OP_PUSH32 = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP   = 3'd1,
    ST_DEC  = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4
  } fetch_state_e;

  // Number of immediate bytes following a PUSH opcode (0 for PUSH0 and non-PUSH).
  function automatic logic [LEN_W-1:0] push_bytes(input logic [7:0] opcode);
    logic [7:0]       diff;
    logic [LEN_W-1:0] n;
    diff = opcode - OP_PUSH0;
    n    = '0;
    if (opcode >= OP_PUSH0 && opcode <= OP_PUSH32) begin
      n = diff[LEN_W-1:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/code_fetch_if.sv
// Handshake bundle for code_fetch: pc request, code memory read port, instruction output.
// Ports: req_valid/req_pc/req_ready, flush, mem_rd/mem_addr/mem_rdata,
//        out_valid/out_ready/out_opcode/out_data/out_pc/out_len.
// slave = fetch unit side, master = requester / memory / consumer side.
interface code_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  import code_fetch_pkg::*;

  logic                 req_valid;
  logic [ADDR_W-1:0]    req_pc;
  logic                 req_ready;
  logic                 flush;

  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [7:0]           mem_rdata;

  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_opcode;
  logic [DATA_W-1:0]    out_data;
  logic [ADDR_W-1:0]    out_pc;
  logic [LEN_W-1:0]     out_len;

  modport slave (
    input  req_valid, req_pc, flush, mem_rdata, out_ready,
    output req_ready, mem_rd, mem_addr, out_valid, out_opcode, out_data, out_pc, out_len
  );

  modport master (
    output req_valid, req_pc, flush, mem_rdata, out_ready,
    input  req_ready, mem_rd, mem_addr, out_valid, out_opcode, out_data, out_pc, out_len
  );

endinterface

// File: rtl/code_fetch_shifter.sv
// Purpose: 256-bit big-endian byte accumulator for PUSH immediates.
// Latency: data_o reflects clear_i/shift_i one cycle after they are asserted.
// Backpressure: none; holds its value whenever neither clear_i nor shift_i is set.
// Ports: clk, rst (async, active-high), clear_i, shift_i, byte_i[7:0], data_o[255:0].
module code_fetch_shifter
  import code_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  // First captured byte ends up most significant, so PUSHk lands in bits [8k-1:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clear_i) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {data_q[DATA_W-9:0], byte_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/code_fetch.sv
// Purpose: fetch one EVM instruction (opcode + PUSH immediate) from byte-wide sync code memory.
// Latency: accept -> out_valid is 2 cycles, plus 1 per PUSH immediate byte (PUSH32: 34).
// Backpressure: outputs held in HOLD until out_ready; new requests only accepted in IDLE.
// Ports: clk, rst (async, active-high), bus (code_fetch_if.slave: request, memory, output).
module code_fetch
  import code_fetch_pkg::*;
#(
  parameter int unsigned CODE_SIZE = 24576,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  code_fetch_if.slave  bus
);

  // One extra bit so pc+k past the top of the address space counts as out of range.
  localparam logic [ADDR_W:0] CODE_LIMIT = (ADDR_W+1)'(CODE_SIZE);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;     // index of the immediate byte captured this DATA cycle
  logic               inr_q, inr_d;     // the read issued last cycle was in range

  logic               issue;
  logic [LEN_W-1:0]   issue_off;
  logic [ADDR_W:0]    issue_addr;
  logic               issue_inr;
  logic [7:0]         byte_in;
  logic [LEN_W-1:0]   dec_n;
  logic               acc_clear;
  logic               acc_shift;
  logic [DATA_W-1:0]  acc_data;

  // Out-of-range slots read as STOP/zero regardless of what the memory bus carries.
  assign byte_in = inr_q ? bus.mem_rdata : OP_STOP;
  assign dec_n   = push_bytes(byte_in);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    issue_off = '0;
    acc_clear = 1'b0;
    acc_shift = 1'b0;

    // flush wins over everything, including a request in the same cycle.
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            pc_d      = bus.req_pc;
            acc_clear = 1'b1;
            state_d   = ST_OP;
          end
        end
        ST_OP: begin
          issue   = 1'b1;
          state_d = ST_DEC;
        end
        ST_DEC: begin
          opcode_d = byte_in;
          n_d      = dec_n;
          len_d    = dec_n + LEN_W'(1);
          cnt_d    = LEN_W'(1);
          if (dec_n == '0) begin
            state_d = ST_HOLD;
          end else begin
            issue     = 1'b1;
            issue_off = LEN_W'(1);
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          acc_shift = 1'b1;
          if (cnt_q == n_q) begin
            state_d = ST_HOLD;
          end else begin
            issue     = 1'b1;
            issue_off = cnt_q + LEN_W'(1);
            cnt_d     = cnt_q + LEN_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign issue_addr = {1'b0, pc_q} + {{(ADDR_W+1-LEN_W){1'b0}}, issue_off};
  assign issue_inr  = issue_addr < CODE_LIMIT;
  assign inr_d      = issue & issue_inr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      opcode_q <= '0;
      len_q    <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      inr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      inr_q    <= inr_d;
    end
  end

  code_fetch_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .shift_i (acc_shift),
    .byte_i  (byte_in),
    .data_o  (acc_data)
  );

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_HOLD);
  assign bus.mem_rd     = issue & issue_inr;
  assign bus.mem_addr   = issue ? issue_addr[ADDR_W-1:0] : '0;
  assign bus.out_opcode = opcode_q;
  assign bus.out_data   = acc_data;
  assign bus.out_pc     = pc_q;
  assign bus.out_len    = len_q;

endmodule

// File: tb/tb_code_fetch.sv
// Directed bench for code_fetch: dut_a uses CODE_SIZE=24576, dut_b uses CODE_SIZE=8.
// Both share one code image; sel picks which DUT receives requests and is observed.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_code_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_fetch_if ifa ();
  code_fetch_if ifb ();

  assign ifa.req_valid = req_valid & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifa.req_pc    = req_pc;
  assign ifb.req_pc    = req_pc;
  assign ifa.flush     = flush;
  assign ifb.flush     = flush;
  assign ifa.out_ready = out_ready & ~sel;
  assign ifb.out_ready = out_ready & sel;

  code_fetch #(.CODE_SIZE(24576), .ADDR_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  code_fetch #(.CODE_SIZE(8),     .ADDR_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Code memory: one-cycle read latency; garbage when no read was issued.
  logic [7:0] code_mem [0:65535];
  always @(posedge clk) begin
    ifa.mem_rdata <= ifa.mem_rd ? code_mem[ifa.mem_addr] : 8'hEE;
    ifb.mem_rdata <= ifb.mem_rd ? code_mem[ifb.mem_addr] : 8'hEE;
  end

  logic         o_valid, o_rready, o_mem_rd;
  logic [15:0]  o_mem_addr, o_pc;
  logic [7:0]   o_opcode;
  logic [255:0] o_data;
  logic [5:0]   o_len;
  assign o_valid    = sel ? ifb.out_valid  : ifa.out_valid;
  assign o_rready   = sel ? ifb.req_ready  : ifa.req_ready;
  assign o_mem_rd   = sel ? ifb.mem_rd     : ifa.mem_rd;
  assign o_mem_addr = sel ? ifb.mem_addr   : ifa.mem_addr;
  assign o_pc       = sel ? ifb.out_pc     : ifa.out_pc;
  assign o_opcode   = sel ? ifb.out_opcode : ifa.out_opcode;
  assign o_data     = sel ? ifb.out_data   : ifa.out_data;
  assign o_len      = sel ? ifb.out_len    : ifa.out_len;

  // Running event counters of the selected DUT; tasks compare deltas.
  int rd_cnt = 0, oor_cnt = 0, vld_cnt = 0;
  always @(posedge clk) begin
    if (o_mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (o_mem_addr >= (sel ? 16'd8 : 16'd24576)) oor_cnt <= oor_cnt + 1;
    end
    if (o_valid) vld_cnt <= vld_cnt + 1;
  end

  // Present a request at a falling edge; returns one cycle later (after acceptance).
  task automatic start_req(input logic s, input logic [15:0] pc);
    sel       = s;
    req_pc    = pc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL %s req_ready: got %b want 1", tag, o_rready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %b want 0", tag, o_valid); end
    checks++; if (o_mem_rd !== 1'b0) begin errors++; $display("FAIL %s mem_rd: got %b want 0", tag, o_mem_rd); end
    checks++; if (o_mem_addr !== 16'h0) begin errors++; $display("FAIL %s mem_addr: got %h want 0", tag, o_mem_addr); end
    checks++; if (o_opcode !== 8'h00) begin errors++; $display("FAIL %s out_opcode: got %h want 00", tag, o_opcode); end
    checks++; if (o_data !== 256'h0) begin errors++; $display("FAIL %s out_data: got %h want 0", tag, o_data); end
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL %s out_pc: got %h want 0", tag, o_pc); end
    checks++; if (o_len !== 6'd0) begin errors++; $display("FAIL %s out_len: got %0d want 0", tag, o_len); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    check_reset_values("reset_a");
    checks++; if (ifb.req_ready !== 1'b1 || ifb.out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_b: got rdy=%b vld=%b want 1/0", ifb.req_ready, ifb.out_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simple();
    int lat, rd0;
    rd0 = rd_cnt;
    start_req(1'b0, 16'd0);
    wait_valid(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL simple latency: got %0d want 2", lat); end
    checks++; if (o_opcode !== 8'h01 || o_data !== 256'h0 || o_len !== 6'd1 || o_pc !== 16'd0)
      begin errors++; $display("FAIL simple out: got op=%h data=%h len=%0d pc=%h want 01/0/1/0", o_opcode, o_data, o_len, o_pc); end
    checks++; if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL simple reads: got %0d want 1", rd_cnt - rd0); end
    consume();
  endtask

  task automatic test_push1();
    int lat, rd0;
    rd0 = rd_cnt;
    start_req(1'b0, 16'd4);
    wait_valid(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL push1 latency: got %0d want 3", lat); end
    checks++; if (o_opcode !== 8'h60 || o_data !== 256'h5A || o_len !== 6'd2 || o_pc !== 16'd4)
      begin errors++; $display("FAIL push1 out: got op=%h data=%h len=%0d pc=%h want 60/5a/2/4", o_opcode, o_data, o_len, o_pc); end
    checks++; if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL push1 reads: got %0d want 2", rd_cnt - rd0); end
    consume();
  endtask

  task automatic test_push32();
    int lat, rd0;
    rd0 = rd_cnt;
    start_req(1'b0, 16'd16);
    wait_valid(lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL push32 latency: got %0d want 34", lat); end
    checks++; if (o_data !== 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20)
      begin errors++; $display("FAIL push32 data: got %h", o_data); end
    checks++; if (o_opcode !== 8'h7F || o_len !== 6'd33)
      begin errors++; $display("FAIL push32 op/len: got %h/%0d want 7f/33", o_opcode, o_len); end
    checks++; if (rd_cnt - rd0 != 33) begin errors++; $display("FAIL push32 reads: got %0d want 33", rd_cnt - rd0); end
    consume();
  endtask

  task automatic test_code_end();
    int lat, rd0, oor0;
    rd0 = rd_cnt; oor0 = oor_cnt;
    start_req(1'b1, 16'd6);
    wait_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL code_end latency: got %0d want 5", lat); end
    checks++; if (o_opcode !== 8'h62 || o_data !== 256'hAB0000 || o_len !== 6'd4)
      begin errors++; $display("FAIL code_end out: got op=%h data=%h len=%0d want 62/ab0000/4", o_opcode, o_data, o_len); end
    checks++; if (rd_cnt - rd0 != 2 || oor_cnt != oor0)
      begin errors++; $display("FAIL code_end reads: got %0d (oor %0d) want 2 (oor 0)", rd_cnt - rd0, oor_cnt - oor0); end
    consume();
  endtask

  task automatic test_oor_pc();
    int lat, rd0;
    rd0 = rd_cnt;
    start_req(1'b1, 16'd100);
    wait_valid(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL oor_pc latency: got %0d want 2", lat); end
    checks++; if (o_opcode !== 8'h00 || o_data !== 256'h0 || o_len !== 6'd1 || o_pc !== 16'd100)
      begin errors++; $display("FAIL oor_pc out: got op=%h data=%h len=%0d pc=%0d want 00/0/1/100", o_opcode, o_data, o_len, o_pc); end
    checks++; if (rd_cnt != rd0) begin errors++; $display("FAIL oor_pc reads: got %0d want 0", rd_cnt - rd0); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    start_req(1'b0, 16'd4);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_rready !== 1'b0 || o_opcode !== 8'h60 || o_data !== 256'h5A || o_pc !== 16'd4 || o_len !== 6'd2)
        begin errors++; $display("FAIL hold cycle %0d: got vld=%b rdy=%b op=%h data=%h pc=%h len=%0d", i, o_valid, o_rready, o_opcode, o_data, o_pc, o_len); end
    end
    consume();
    checks++; if (o_valid !== 1'b0 || o_rready !== 1'b1)
      begin errors++; $display("FAIL hold release: got vld=%b rdy=%b want 0/1", o_valid, o_rready); end
  endtask

  task automatic test_flush();
    int lat, v0;
    start_req(1'b0, 16'd64);
    repeat (4) @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_pc = 16'd0;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (o_rready !== 1'b1 || o_valid !== 1'b0 || o_mem_rd !== 1'b0 || o_pc !== 16'd64)
      begin errors++; $display("FAIL flush state: got rdy=%b vld=%b rd=%b pc=%h want 1/0/0/0040", o_rready, o_valid, o_mem_rd, o_pc); end
    v0 = vld_cnt;
    repeat (40) @(negedge clk);
    checks++; if (vld_cnt != v0) begin errors++; $display("FAIL flush no_output: got %0d valid cycles want 0", vld_cnt - v0); end
    start_req(1'b0, 16'd64);
    wait_valid(lat);
    checks++; if (lat != 22) begin errors++; $display("FAIL refetch latency: got %0d want 22", lat); end
    checks++; if (o_opcode !== 8'h73 || o_len !== 6'd21 || o_data !== 256'hc1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4)
      begin errors++; $display("FAIL refetch out: got op=%h len=%0d data=%h", o_opcode, o_len, o_data); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_req(1'b0, 16'd0);
    wait_valid(lat);
    consume();
    checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL b2b ready: got %b want 1", o_rready); end
    start_req(1'b0, 16'd4);
    wait_valid(lat);
    checks++; if (lat != 3 || o_data !== 256'h5A || o_pc !== 16'd4)
      begin errors++; $display("FAIL b2b second: got lat=%0d data=%h pc=%h want 3/5a/4", lat, o_data, o_pc); end
    consume();
  endtask

  task automatic test_reset_mid();
    int v0;
    start_req(1'b0, 16'd16);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    v0 = vld_cnt;
    repeat (40) @(negedge clk);
    checks++; if (vld_cnt != v0 || o_rready !== 1'b1)
      begin errors++; $display("FAIL rst_mid after: got %0d valid cycles rdy=%b want 0/1", vld_cnt - v0, o_rready); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) code_mem[i] = 8'h00;
    code_mem[0] = 8'h01;
    code_mem[4] = 8'h60; code_mem[5] = 8'h5A;
    code_mem[6] = 8'h62; code_mem[7] = 8'hAB; code_mem[8] = 8'h11; code_mem[9] = 8'h22;
    code_mem[16] = 8'h7F;
    for (int i = 1; i <= 32; i++) code_mem[16+i] = 8'(i);
    code_mem[64] = 8'h73;
    for (int i = 0; i < 20; i++) code_mem[65+i] = 8'(8'hC1 + i);
    code_mem[100] = 8'h60;

    test_reset();
    test_simple();
    test_push1();
    test_push32();
    test_code_end();
    test_oor_pc();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/code_fetch.md
Name: code_fetch

Overview:
- Stage directly upstream of the execution core.
- Takes a program-counter request, reads contract bytecode from a byte-wide synchronous code memory, and delivers one decoded instruction:
  - the opcode byte;
  - for PUSH0..PUSH32, the immediate bytes, right-aligned and zero-padded in a 256-bit word.
- Applies EVM code-end semantics: bytes at or past the code size read as 0x00.

Parameters:
- CODE_SIZE, 24576, number of valid code bytes (1..65536); addresses >= CODE_SIZE read as 0x00.
- ADDR_W, 16, width of pc and memory address.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pc request valid
- req_pc  in  16  pc of the instruction to fetch
- req_ready  out  1  fetch unit idle and able to accept a request
- flush  in  1  abort the current fetch and drop any held result
- mem_rd  out  1  code memory read strobe
- mem_addr  out  16  code memory byte address
- mem_rdata  in  8  read data, valid the cycle after mem_rd
- out_valid  out  1  instruction available
- out_ready  in  1  consumer accepts the instruction
- out_opcode  out  8  opcode byte
- out_data  out  256  PUSH immediate (code_data)
- out_pc  out  16  pc of the delivered instruction
- out_len  out  6  bytes consumed by the instruction: 1 + n for PUSHn, else 1

Behaviour:
- Reset values:
  - state IDLE;
  - req_ready=1;
  - mem_rd=0, mem_addr=0;
  - out_valid=0;
  - out_opcode=0, out_data=0, out_pc=0, out_len=0.
- States:
  - IDLE: req_ready=1; req_valid&&req_ready latches pc and goes to OP.
  - OP: issues the opcode read; goes to DEC.
  - DEC: mem_rdata is the opcode; state is fixed for the rest of the fetch.
    - n = opcode-0x5F for 0x5F..0x7F, else 0.
    - n=0 goes to HOLD.
    - n>0 issues pc+1 in the same cycle and goes to DATA.
  - DATA: each cycle captures the previous byte and issues the next address. Goes to HOLD after the n-th byte is captured.
  - HOLD: out_valid=1. out_ready goes to IDLE.
- Outputs are held stable while out_valid && !out_ready.
- mem_addr is driven during OP and DATA; mem_rd is asserted with it. No read is issued for addresses >= CODE_SIZE.
- Memory read latency is fixed at 1 cycle. No memory backpressure.
- Latency from request acceptance to out_valid rising:
  - non-PUSH and PUSH0: 2 cycles;
  - PUSHn: 2+n cycles;
  - PUSH32: 34 cycles.
- Each issued address is compared against CODE_SIZE in 17 bits, so pc+k past 0xFFFF counts as out of range.
- A per-slot registered in-range flag marks each issue. An out-of-range slot injects byte 0x00 in place of mem_rdata.
- If pc >= CODE_SIZE, out_opcode=0x00 (STOP) with the normal 2-cycle latency.
- Immediate assembly (big-endian): each captured byte is shifted in as out_data = {out_data[247:0], byte]}. out_data is cleared on request acceptance. PUSHk yields value in bits [8k-1:0], upper bits zero.
- out_len = n+1. The consumer computes next pc = out_pc + out_len.
- flush (synchronous, any state):
  - next state IDLE, out_valid=0;
  - mem_rd deasserted the following cycle;
  - the in-flight read is discarded;
  - flush takes priority over a same-cycle request.
- Back-to-back: a new request is accepted only in IDLE, so the minimum gap is one IDLE cycle after the out handshake.
- Asynchronous reset mid-fetch returns to reset values immediately. No partial result is ever emitted.

Decomposition:
- Shared package:
  - fetch state enum;
  - opcode constants OP_STOP=0x00, OP_PUSH0=0x5F, OP_PUSH32=0x7F;
  - function push_bytes(opcode) returning n.
- One natural sub-module, code_fetch_shifter: 256-bit big-endian byte accumulator with clear and shift-in-byte ports.
- FSM and address generation stay in code_fetch.

Test Plan:
- Code 0x01 at pc 0; request pc=0 -> out_valid 2 cycles after accept; opcode=0x01, out_data=0, out_len=1.
- Code 0x60 0x5A at pc 4 -> 3 cycles; opcode=0x60, out_data=0x5A, out_len=2, out_pc=4.
- PUSH32 followed by bytes 0x01..0x20 -> 34 cycles; out_data=0x0102...1F20; exactly 33 mem_rd pulses.
- CODE_SIZE=8, code[6]=0x62 (PUSH3), code[7]=0xAB, pc=6:
  - out_data=0xAB0000;
  - no mem_rd for addresses 8 and 9.
- Request pc=100 with CODE_SIZE=8 -> opcode=0x00, out_data=0, zero mem_rd pulses.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles -> outputs stable, req_ready=0; release -> IDLE next cycle.
  - flush during the DATA state of a PUSH20 -> no out_valid; next request returns correct data.
  - rst asserted mid-DATA -> all outputs at reset values immediately.
